// File: rtl/audio_mem_stream_reader_if.sv
// rtl/audio_mem_stream_reader_if.sv - memory read port and sample stream bundle for audio_mem_stream_reader
//
// Memory side (Avalon-MM read master, no waitrequest):
//   m_address, m_chipselect, m_write, m_byteenable, m_writedata, m_clken  master -> memory
//   m_readdata                                                             memory -> master
// Stream side (valid/ready toward the codec serializer):
//   st_data, st_valid  master -> sink
//   st_ready           sink -> master
interface audio_mem_stream_reader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   m_address;
    logic                    m_chipselect;
    logic                    m_write;
    logic [DATA_WIDTH/8-1:0] m_byteenable;
    logic [DATA_WIDTH-1:0]   m_writedata;
    logic                    m_clken;
    logic [DATA_WIDTH-1:0]   m_readdata;
    logic [DATA_WIDTH-1:0]   st_data;
    logic                    st_valid;
    logic                    st_ready;

    modport master (
        output m_address, m_chipselect, m_write, m_byteenable, m_writedata, m_clken,
        input  m_readdata,
        output st_data, st_valid,
        input  st_ready
    );

    modport slave (
        input  m_address, m_chipselect, m_write, m_byteenable, m_writedata, m_clken,
        output m_readdata,
        input  st_data, st_valid,
        output st_ready
    );
endinterface

// File: rtl/audio_mem_stream_reader.sv
// rtl/audio_mem_stream_reader.sv - block/loop sample fetcher from on-chip memory onto a valid/ready stream
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   start, abort          one-cycle control pulses (abort wins over start)
//   loop_en               sampled at start: repeat the block until aborted
//   base_addr, num_words  block definition, sampled at start
//   busy                  high while in RUN or DRAIN
//   done                  one-cycle pulse after the last word of a non-loop block leaves the stream
//   bus                   master side of the memory read port and the sample stream
module audio_mem_stream_reader #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   loop_en,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [15:0]            num_words,
    output logic                   busy,
    output logic                   done,
    audio_mem_stream_reader_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_ptr;
    logic [ADDR_WIDTH-1:0]   base_r;
    logic [15:0]             remaining;
    logic [15:0]             num_r;
    logic                    loop_r;
    logic [READ_LATENCY-1:0] pipe;
    logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           fifo_count;
    logic [CW-1:0]           in_flight;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    fifo_nonempty;
    logic                    drain_empty;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            in_flight = in_flight + CW'(pipe[i]);
        end
    end

    // Credit check uses only registered counts, so st_ready never reaches m_chipselect.
    // Every issued read already owns a FIFO slot, which is why a capture cannot overflow.
    assign issue         = (state == RUN) && (remaining != 16'd0) &&
                           ((fifo_count + in_flight) < CW'(FIFO_DEPTH));
    assign push          = pipe[READ_LATENCY-1];
    assign fifo_nonempty = (fifo_count != '0);
    assign pop           = fifo_nonempty && bus.st_ready;
    // Block is finished once nothing is in flight and the FIFO is empty or losing its last word now.
    assign drain_empty   = (in_flight == '0) &&
                           ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

    assign busy             = (state != IDLE);
    assign bus.m_address    = addr_ptr;
    assign bus.m_chipselect = issue;
    assign bus.m_write      = 1'b0;
    assign bus.m_byteenable = '1;
    assign bus.m_writedata  = '0;
    assign bus.m_clken      = 1'b1;
    assign bus.st_valid     = fifo_nonempty;
    assign bus.st_data      = fifo_nonempty ? fifo_mem[rd_ptr] : '0;

    // Storage only; occupancy is governed by the pointers and fifo_count below.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.m_readdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state      <= IDLE;
            done       <= 1'b0;
            pipe       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            remaining  <= '0;
            if (reset) begin
                addr_ptr <= '0;
                base_r   <= '0;
                num_r    <= '0;
                loop_r   <= 1'b0;
            end
        end else begin
            done <= 1'b0;

            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                pipe[i] <= pipe[i-1];
            end
            pipe[0] <= issue;

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase

            case (state)
                IDLE: begin
                    if (start) begin
                        base_r <= base_addr;
                        num_r  <= num_words;
                        loop_r <= loop_en;
                        if (num_words == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= RUN;
                            addr_ptr  <= base_addr;
                            remaining <= num_words;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (remaining == 16'd1) begin
                            if (loop_r) begin
                                // Reload in the same cycle so looped playback has no gap.
                                addr_ptr  <= base_r;
                                remaining <= num_r;
                            end else begin
                                addr_ptr  <= addr_ptr + ADDR_WIDTH'(1);
                                remaining <= 16'd0;
                                state     <= DRAIN;
                            end
                        end else begin
                            addr_ptr  <= addr_ptr + ADDR_WIDTH'(1);
                            remaining <= remaining - 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_mem_stream_reader.sv
// tb/tb_audio_mem_stream_reader.sv - directed self-checking bench for audio_mem_stream_reader
module tb_audio_mem_stream_reader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        loop_en;
    logic [15:0] base_addr;
    logic [15:0] num_words;
    logic        busy;
    logic        done;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    audio_mem_stream_reader_if bus ();

    audio_mem_stream_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .loop_en   (loop_en),
        .base_addr (base_addr),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    // Memory model: address registered on chipselect, data out unregistered; mem[a] = a[7:0] in every byte.
    logic [15:0] rd_addr = 16'h0000;
    always @(posedge clk) if (bus.m_chipselect) rd_addr <= bus.m_address;
    assign bus.m_readdata = {4{rd_addr[7:0]}};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] cs_q[$];
    int          cs_cyc[$];
    logic [31:0] rx_q[$];
    int          rx_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    bit          busy_seen = 0;
    int          stab_err = 0;
    bit          hold = 0;
    logic [31:0] hold_data = '0;

    always @(negedge clk) begin
        if (bus.m_chipselect === 1'b1) begin
            cs_q.push_back(bus.m_address);
            cs_cyc.push_back(cyc);
        end
        if (bus.st_valid === 1'b1 && bus.st_ready === 1'b1) begin
            rx_q.push_back(bus.st_data);
            rx_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy === 1'b1) busy_seen = 1;
        if (hold && (bus.st_valid !== 1'b1 || bus.st_data !== hold_data)) stab_err++;
        hold      = (bus.st_valid === 1'b1) && (bus.st_ready === 1'b0);
        hold_data = bus.st_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        cs_q.delete();
        cs_cyc.delete();
        rx_q.delete();
        rx_cyc.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        busy_seen = 0;
        stab_err  = 0;
    endtask

    task automatic pulse_start(input logic [15:0] b, input logic [15:0] n, input logic l);
        base_addr = b;
        num_words = n;
        loop_en   = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (done === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    function automatic logic [31:0] rx_at(input int i);
        return (i < rx_q.size()) ? rx_q[i] : 32'hxxxxxxxx;
    endfunction

    function automatic logic [15:0] cs_at(input int i);
        return (i < cs_q.size()) ? cs_q[i] : 16'hxxxx;
    endfunction

    initial begin
        #100000;
        $display("FAIL global_timeout: observed still running expected finished");
        $fatal(1);
    end

    initial begin
        bit          ok;
        int          n_rx;
        int          bad;
        logic [15:0] wrap_a [4];
        logic [31:0] wrap_d [4];
        logic [7:0]  b8;

        wrap_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        wrap_d = '{32'hFEFEFEFE, 32'hFFFFFFFF, 32'h00000000, 32'h01010101};

        reset = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
        base_addr = '0; num_words = '0; bus.st_ready = 1'b1;
        repeat (3) tick();

        check("rst_busy",    busy,             0);
        check("rst_done",    done,             0);
        check("rst_cs",      bus.m_chipselect, 0);
        check("rst_addr",    bus.m_address,    0);
        check("rst_valid",   bus.st_valid,     0);
        check("rst_data",    bus.st_data,      0);
        check("rst_write",   bus.m_write,      0);
        check("rst_be",      bus.m_byteenable, 32'hF);
        check("rst_wdata",   bus.m_writedata,  0);
        check("rst_clken",   bus.m_clken,      1);
        reset = 1'b0;
        tick();

        // Single block at full throughput
        clear_logs();
        pulse_start(16'h0010, 16'd4, 1'b0);
        wait_done(50, ok);
        check("blk_done_seen", ok, 1);
        check("blk_busy_at_done", busy, 0);
        repeat (2) tick();
        check("blk_cs_count", cs_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("blk_addr%0d", i), cs_at(i), 32'(16'h0010 + i));
            b8 = 8'(16'h10 + i);
            check($sformatf("blk_data%0d", i), rx_at(i), {4{b8}});
        end
        check("blk_rx_count", rx_q.size(), 4);
        check("blk_back_to_back", (rx_cyc.size() == 4) ? rx_cyc[3] - rx_cyc[0] : -1, 3);
        check("blk_done_count", done_cnt, 1);
        check("blk_done_timing", done_cyc, (rx_cyc.size() == 4) ? rx_cyc[3] + 1 : -99);

        // Backpressure: reads stall at FIFO_DEPTH, then drain in order
        clear_logs();
        bus.st_ready = 1'b0;
        pulse_start(16'h0020, 16'd16, 1'b0);
        repeat (20) tick();
        check("bp_stall_reads", cs_q.size(), 4);
        check("bp_valid", bus.st_valid, 1);
        check("bp_head", bus.st_data, 32'h20202020);
        check("bp_busy", busy, 1);
        bus.st_ready = 1'b1;
        wait_done(100, ok);
        check("bp_done_seen", ok, 1);
        repeat (2) tick();
        check("bp_rx_count", rx_q.size(), 16);
        check("bp_cs_count", cs_q.size(), 16);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            b8 = 8'(16'h20 + i);
            if (rx_at(i) !== {4{b8}}) bad++;
        end
        check("bp_data_order", bad, 0);
        check("bp_hold_stable", stab_err, 0);

        // Address wrap at the top of the memory
        clear_logs();
        pulse_start(16'hFFFE, 16'd4, 1'b0);
        wait_done(50, ok);
        check("wrap_done_seen", ok, 1);
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_addr%0d", i), cs_at(i), 32'(wrap_a[i]));
            check($sformatf("wrap_data%0d", i), rx_at(i), wrap_d[i]);
        end

        // Looped playback with an ignored start, then abort
        clear_logs();
        pulse_start(16'h0100, 16'd3, 1'b1);
        repeat (5) tick();
        pulse_start(16'h0500, 16'd7, 1'b0);
        repeat (10) tick();
        check("loop_enough_reads", cs_q.size() >= 12, 1);
        bad = 0;
        for (int i = 0; i < cs_q.size(); i++) begin
            if (cs_q[i] !== 16'(16'h0100 + (i % 3))) bad++;
        end
        check("loop_addr_seq", bad, 0);
        bad = 0;
        for (int i = 1; i < cs_cyc.size(); i++) begin
            if (cs_cyc[i] != cs_cyc[i-1] + 1) bad++;
        end
        check("loop_no_gap", bad, 0);
        check("loop_no_done", done_cnt, 0);
        check("loop_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", bus.st_valid, 0);
        check("abort_cs", bus.m_chipselect, 0);
        n_rx = rx_q.size();
        repeat (4) tick();
        check("abort_no_rx", rx_q.size(), n_rx);
        check("abort_valid_later", bus.st_valid, 0);
        check("abort_no_done", done_cnt, 0);

        // Zero-length block
        clear_logs();
        pulse_start(16'h0030, 16'd0, 1'b0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        tick();
        check("zero_done_drop", done, 0);
        tick();
        check("zero_busy_never", busy_seen, 0);
        check("zero_no_reads", cs_q.size(), 0);
        check("zero_done_count", done_cnt, 1);

        // Reset mid-block, then a clean restart from a new base
        clear_logs();
        pulse_start(16'h0040, 16'd10, 1'b0);
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (rx_q.size() >= 5) begin
                ok = 1;
                break;
            end
        end
        check("mid_reached_word5", ok, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_cs",    bus.m_chipselect, 0);
        check("mid_rst_addr",  bus.m_address,    0);
        check("mid_rst_valid", bus.st_valid,     0);
        check("mid_rst_data",  bus.st_data,      0);
        check("mid_rst_busy",  busy,             0);
        check("mid_rst_done",  done,             0);
        reset = 1'b0;
        tick();
        clear_logs();
        pulse_start(16'h0060, 16'd3, 1'b0);
        wait_done(50, ok);
        check("restart_done_seen", ok, 1);
        repeat (2) tick();
        check("restart_cs_count", cs_q.size(), 3);
        check("restart_rx_count", rx_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            b8 = 8'(16'h60 + i);
            check($sformatf("restart_data%0d", i), rx_at(i), {4{b8}});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
